program_counter: RTL

//  Architectural PC register directly downstream of the branch/immediate mux.

---
 rtl/program_counter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/program_counter.sv
// program_counter
//   Architectural PC register sitting after the branch/immediate mux. Holds the
//   current fetch address, runs a req/ack fetch handshake to instruction BRAM,
//   and advances by +1 or loads the mux result when the control unit asks.
//   A fetch that is never acknowledged within FETCH_TMO cycles parks the block
//   in a terminal fault state that only reset leaves.
//   Optional feature: define PC_RETURN_STACK_EN to add a circular call/return
//   stack (rs_push / rs_pop / rs_uflow) of RS_DEPTH entries.
module program_counter #(
    parameter int              AW           = 10,
    parameter logic [AW-1:0]   RESET_VECTOR = '0,
    parameter int              FETCH_TMO    = 15
`ifdef PC_RETURN_STACK_EN
    ,
    parameter int              RS_DEPTH     = 4
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_load,
    input  logic          pc_inc,
    input  logic          stall,
    input  logic          fetch_ack,
`ifdef PC_RETURN_STACK_EN
    input  logic          rs_push,
    input  logic          rs_pop,
    output logic          rs_uflow,
`endif
    output logic          fetch_req,
    output logic [AW-1:0] fetch_addr,
    output logic [AW-1:0] pc_out,
    output logic          busy,
    output logic          wrap,
    output logic          fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_FAULT
    } state_t;

    // Last count value that is still tolerated before the fetch is declared lost.
    localparam logic [7:0] TMO_LAST = 8'(FETCH_TMO - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_plus1;
    logic [7:0]    tmo_q, tmo_d;
    logic          fault_q, fault_d;
    logic          wrap_q, wrap_d;

    assign pc_plus1 = pc_q + AW'(1);

`ifdef PC_RETURN_STACK_EN
    localparam int            PW       = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int            CW       = $clog2(RS_DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(RS_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RS_DEPTH);

    // sp_q is the next slot to write; the top of stack sits just below it.
    logic [AW-1:0] rs_mem [RS_DEPTH];
    logic [PW-1:0] sp_q, sp_d, top_idx, next_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_we;
    logic          rs_uflow_q, rs_uflow_d;

    assign top_idx  = (sp_q == '0) ? LAST_IDX : sp_q - PW'(1);
    assign next_idx = (sp_q == LAST_IDX) ? '0 : sp_q + PW'(1);
`endif

    // Next-state, next-PC and handshake bookkeeping.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        tmo_d   = tmo_q;
        fault_d = fault_q;
        wrap_d  = 1'b0;
`ifdef PC_RETURN_STACK_EN
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        rs_we      = 1'b0;
        rs_uflow_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                if (fetch_ack) begin
                    state_d = S_EXEC;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            S_EXEC: begin
                if (!stall) begin
`ifdef PC_RETURN_STACK_EN
                    if (rs_pop) begin
                        state_d = S_FETCH;
                        if (cnt_q == '0) begin
                            pc_d       = RESET_VECTOR;
                            rs_uflow_d = 1'b1;
                        end else begin
                            pc_d  = rs_mem[top_idx];
                            sp_d  = top_idx;
                            cnt_d = cnt_q - CW'(1);
                        end
                    end else if (rs_push) begin
                        // Full stack: the write lands on the oldest slot.
                        state_d = S_FETCH;
                        pc_d    = pc_in;
                        rs_we   = 1'b1;
                        sp_d    = next_idx;
                        cnt_d   = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + CW'(1);
                    end else
`endif
                    if (pc_load) begin
                        state_d = S_FETCH;
                        pc_d    = pc_in;
                    end else if (pc_inc) begin
                        state_d = S_FETCH;
                        pc_d    = pc_plus1;
                        wrap_d  = (pc_q == '1);
                    end
                end
            end

            S_FAULT: state_d = S_FAULT;

            default: state_d = S_IDLE;
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            tmo_q   <= '0;
            fault_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef PC_RETURN_STACK_EN
    // Stack pointer, occupancy and underflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q       <= '0;
            cnt_q      <= '0;
            rs_uflow_q <= 1'b0;
        end else begin
            sp_q       <= sp_d;
            cnt_q      <= cnt_d;
            rs_uflow_q <= rs_uflow_d;
        end
    end

    // Return-address storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; emptiness is
        // tracked by cnt_q, so stale contents are never read.
        if (rs_we) rs_mem[sp_q] <= pc_plus1;
    end

    assign rs_uflow = rs_uflow_q;
`endif

    // fetch_req/busy decode straight from state so an async reset drops them at once.
    assign fetch_req  = (state_q == S_FETCH);
    assign busy       = (state_q == S_FETCH);
    assign fetch_addr = pc_q;
    assign pc_out     = pc_q;
    assign wrap       = wrap_q;
    assign fault      = fault_q;

endmodule
